// File: rtl/window_sum_delay_if.sv
// Sample-path bundle for window_sum_delay.
// Carries load/flush controls, tap select, and delayed-sample/window-sum results.
interface window_sum_delay_if #(
  parameter int N = 36,
  parameter int D = 16
);
  localparam int AW = $clog2(D);
  localparam int SW = N + AW;

  logic                 ld;
  logic [N-1:0]         inp;
  logic                 flush;
  logic [AW-1:0]        tap_sel;
  logic [N-1:0]         tap_out;
  logic [N-1:0]         out;
  logic signed [SW-1:0] sum;
  logic [AW:0]          cnt;
  logic                 full;

  modport master (
    output ld, inp, flush, tap_sel,
    input  tap_out, out, sum, cnt, full
  );

  modport slave (
    input  ld, inp, flush, tap_sel,
    output tap_out, out, sum, cnt, full
  );
endinterface

// File: rtl/window_sum_delay.sv
// D-stage load-enabled delay line with selectable tap,
// registered sliding-window sum and fill counter.
module window_sum_delay #(
  parameter int N = 36,
  parameter int D = 16
) (
  input logic               clk,
  input logic               rst,
  window_sum_delay_if.slave bus
);
  localparam int AW = $clog2(D);
  localparam int SW = N + AW;
  localparam logic [AW:0] W_D   = (AW+1)'(D);
  localparam logic [AW:0] W_ONE = (AW+1)'(1);

  logic [N-1:0]         r_stage [D];
  logic signed [SW-1:0] r_sum;
  logic [AW:0]          r_cnt;

  logic signed [SW-1:0] w_in_ext;
  logic signed [SW-1:0] w_tail_ext;

  assign w_in_ext   = {{AW{bus.inp[N-1]}}, bus.inp};
  assign w_tail_ext = {{AW{r_stage[D-1][N-1]}}, r_stage[D-1]};

  // Cleared stages hold zero, so subtracting the tail keeps the sum exact during fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < D; k++) r_stage[k] <= '0;
      r_sum <= '0;
      r_cnt <= '0;
    end else if (bus.flush) begin
      for (int k = 1; k < D; k++) r_stage[k] <= '0;
      r_stage[0] <= bus.ld ? bus.inp : '0;
      r_sum      <= bus.ld ? w_in_ext : '0;
      r_cnt      <= bus.ld ? W_ONE : '0;
    end else if (bus.ld) begin
      r_stage[0] <= bus.inp;
      for (int k = 1; k < D; k++) r_stage[k] <= r_stage[k-1];
      r_sum <= r_sum + w_in_ext - w_tail_ext;
      if (r_cnt != W_D) r_cnt <= r_cnt + W_ONE;
    end
  end

  always_comb begin
    bus.tap_out = '0;
    if ({1'b0, bus.tap_sel} < W_D) bus.tap_out = r_stage[bus.tap_sel];
  end

  assign bus.out  = r_stage[D-1];
  assign bus.sum  = r_sum;
  assign bus.cnt  = r_cnt;
  assign bus.full = (r_cnt == W_D);
endmodule
